ysyx_24100006_scoreboard: RTL and testbench
===========================================

# ysyx_24100006_scoreboard

Register scoreboard for the ysyx_24100006 in-order pipeline. It tracks outstanding GPR writes between ID issue and WB retire with a small counter per architectural register, and raises `stall_id` while an ID-stage source operand is still pending. It replaces per-stage rd comparison with state that is correct regardless of how long EX/MEM sit in a bus wait or load-use bubble. It sits beside the ID stage: it observes the ID→EX handshake and the WB write port.

## Interface
- `NR_REG`, 16: number of GPRs (RV32E); index width is 4.
- `CNT_W`, 2: pending-write counter width; maximum in-flight writes per register is 2^CNT_W−1.
- `clock`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `id_out_valid`  in  1  ID holds a valid decoded instruction.
- `ex_in_ready`  in  1  EX can accept from ID this cycle.
- `id_rs1`, `id_rs2`  in  4  source register indices.
- `id_rs1_ren`, `id_rs2_ren`  in  1  source actually read.
- `id_rd`  in  4  destination index.
- `id_wen`  in  1  instruction writes rd.
- `wb_valid`  in  1  WB commits an instruction this cycle.
- `wb_rd`  in  4  WB destination.
- `wb_wen`  in  1  WB writes the GPR file this cycle.
- `stall_id`  out  1  hold ID; ID→EX transfer must not occur.
- `busy_vec`  out  16  bit i = counter i nonzero (debug/difftest).
- `sb_err`  out  1  sticky: retire to a register with count 0.
- `perf_stall`  out  32  cycles in which `stall_id` was high.

## Operation
- Definitions:
  - `issue = id_out_valid & ex_in_ready & ~stall_id & id_wen & (id_rd != 0)`.
  - `retire = wb_valid & wb_wen & (wb_rd != 0)`.
- Counter update per register i, evaluated every clock:
  - issue only, to i: +1.
  - retire only, from i: −1.
  - Both in the same cycle to the same i: unchanged.
  - Issue and retire to different registers: each updates independently.
- `x0` is never tracked: cnt[0] is constant 0, and a source index of 0 never stalls.
- `stall_id = id_out_valid & (hz1 | hz2 | waw_full)`:
  - `hz1 = id_rs1_ren & (id_rs1 != 0) & (cnt[id_rs1] != 0)`; `hz2` is the same for rs2.
  - `waw_full = id_wen & (id_rd != 0) & (cnt[id_rd] == max)`. This prevents counter overflow.
- No WB bypass inside the block. A register retiring in cycle N is still counted in cycle N, so stall releases in cycle N+1, when the regfile already holds the new value.
- Underflow (`retire` with cnt[wb_rd] == 0):
  - Counter stays 0.
  - `sb_err` sets and holds until reset.
- `perf_stall` increments when `stall_id` is high and wraps at 2^32.
- ID instructions that are squashed never issue, so squashing has no scoreboard effect. Already-issued instructions are never killed in this pipeline.

## Timing
- Reset values: all counters 0; `busy_vec` = 0; `sb_err` = 0; `perf_stall` = 0.
- `stall_id` is 0 after reset unless an input presents a hazard. It depends only on counters after reset.
- `stall_id` and `busy_vec` are combinational from the counter state and the current ID inputs. There is no path from `ex_in_ready` to `stall_id`.
- Counters, `sb_err` and `perf_stall` update on the rising `clock` edge.
- Latency:
  - Issue in cycle N → a dependent instruction in ID stalls from cycle N+1.
  - Retire in cycle N → stall drops in cycle N+1.
- Reset asserted mid-operation clears all state at that edge. The pipeline is reset in the same cycle.

## Structure
- Constants for the shared `ysyx_24100006` package: `REG_IDX_W` = 4, `NR_REG`, `SB_CNT_W`.
- One natural sub-module, `ysyx_24100006_sb_cnt`: a single saturating up/down counter with `inc`, `dec`, `zero` and `full` outputs. Instantiate it 15 times (x1..x15).
- The hazard logic and perf counter live in the top module.

## Test plan
- Back-to-back dependence:
  - Stimulus: issue `addi x5`, then ID holds `add x6,x5,x5`.
  - Required: `stall_id` = 1 and `busy_vec[5]` = 1 until `wb_rd`=5 retires; `stall_id` = 0 the next cycle.
- x0 handling:
  - Stimulus: issue with `id_rd`=0, then ID reads rs1=0.
  - Required: `busy_vec` stays 0 and `stall_id` stays 0.
- Same-cycle issue/retire to x7 with cnt[7]=1:
  - Required: cnt[7] stays 1 and `busy_vec[7]` stays 1.
  - Then one further retire → 0.
- WAW saturation:
  - Stimulus: 3 issues to x3 with no retire, then a 4th instruction writing x3.
  - Required: `stall_id` = 1 for the 4th; cnt[3] = 3 and does not wrap.
- Underflow:
  - Stimulus: retire `wb_rd`=9 with cnt[9]=0.
  - Required: `sb_err` = 1 and holds through later traffic; clears only on `reset`.
- Perf counter and reset:
  - Stimulus: hold a hazard for 10 cycles.
  - Required: `perf_stall` = 10.
  - Then assert `reset` with counters nonzero → next cycle all counters 0, `perf_stall` = 0, `stall_id` = 0.

Source files
------------

// File: rtl/ysyx_24100006_pkg.sv
// Shared constants and types for the ysyx_24100006 core.
// Register-index width, GPR count and scoreboard counter width.
package ysyx_24100006_pkg;

  localparam int REG_IDX_W = 4;
  localparam int NR_REG    = 16;
  localparam int SB_CNT_W  = 2;
  localparam int PERF_W    = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // One ID-stage source operand.
  typedef struct packed {
    logic     ren;
    reg_idx_t idx;
  } src_op_t;

  function automatic logic src_live(
    input src_op_t s
  );
    return s.ren && (s.idx != '0);
  endfunction

endpackage

// File: rtl/ysyx_24100006_sb_cnt.sv
// Saturating up/down pending-write counter for one GPR.
// Simultaneous inc and dec cancel out.
module ysyx_24100006_sb_cnt
  import ysyx_24100006_pkg::*;
#(
  parameter int W = SB_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic full
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign zero = (cnt_q == '0);
  assign full = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      (inc && !dec && !full): cnt_d = cnt_q + W'(1);
      (dec && !inc && !zero): cnt_d = cnt_q - W'(1);
      default:                cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_24100006_scoreboard.sv
// GPR scoreboard: pending-write counters between ID issue and WB retire.
// Stalls ID on RAW against an in-flight write or a saturated counter.
module ysyx_24100006_scoreboard
  import ysyx_24100006_pkg::*;
#(
  parameter int NR_REG = ysyx_24100006_pkg::NR_REG,
  parameter int CNT_W  = ysyx_24100006_pkg::SB_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_out_valid,
  input  logic              ex_in_ready,
  input  reg_idx_t          id_rs1,
  input  reg_idx_t          id_rs2,
  input  logic              id_rs1_ren,
  input  logic              id_rs2_ren,
  input  reg_idx_t          id_rd,
  input  logic              id_wen,
  input  logic              wb_valid,
  input  reg_idx_t          wb_rd,
  input  logic              wb_wen,
  output logic              stall_id,
  output logic [NR_REG-1:0] busy_vec,
  output logic              sb_err,
  output logic [PERF_W-1:0] perf_stall
);

  logic [NR_REG-1:0] zero_vec;
  logic [NR_REG-1:0] full_vec;

  src_op_t src1;
  src_op_t src2;

  logic hz1;
  logic hz2;
  logic waw_full;
  logic stall;
  logic issue;
  logic retire;

  logic              sb_err_q;
  logic              sb_err_d;
  logic [PERF_W-1:0] perf_q;
  logic [PERF_W-1:0] perf_d;

  // x0 is hard-wired idle: never busy, never full.
  assign zero_vec[0] = 1'b1;
  assign full_vec[0] = 1'b0;

  assign src1 = '{ren: id_rs1_ren, idx: id_rs1};
  assign src2 = '{ren: id_rs2_ren, idx: id_rs2};

  always_comb begin
    hz1      = src_live(src1) && !zero_vec[id_rs1];
    hz2      = src_live(src2) && !zero_vec[id_rs2];
    waw_full = id_wen && (id_rd != '0) && full_vec[id_rd];
    stall    = id_out_valid && (hz1 || hz2 || waw_full);
    issue    = id_out_valid && ex_in_ready && !stall
            && id_wen && (id_rd != '0);
    retire   = wb_valid && wb_wen && (wb_rd != '0);
  end

  for (genvar i = 1; i < NR_REG; i++) begin : g_cnt
    ysyx_24100006_sb_cnt #(
      .W(CNT_W)
    ) u_cnt (
      .clock(clock),
      .reset(reset),
      .inc  (issue && (id_rd == reg_idx_t'(i))),
      .dec  (retire && (wb_rd == reg_idx_t'(i))),
      .zero (zero_vec[i]),
      .full (full_vec[i])
    );
  end

  always_comb begin
    sb_err_d = sb_err_q || (retire && zero_vec[wb_rd]);
    perf_d   = perf_q + PERF_W'(stall);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sb_err_q <= 1'b0;
      perf_q   <= '0;
    end else begin
      sb_err_q <= sb_err_d;
      perf_q   <= perf_d;
    end
  end

  assign stall_id   = stall;
  assign busy_vec   = ~zero_vec;
  assign sb_err     = sb_err_q;
  assign perf_stall = perf_q;

endmodule

// File: tb/tb_ysyx_24100006_scoreboard.sv
// Directed bench for the GPR scoreboard with a per-cycle reference model.
// Model keeps plain integer counts per register.
module tb_ysyx_24100006_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        id_out_valid = 1'b0;
  logic        ex_in_ready = 1'b0;
  logic [3:0]  id_rs1 = '0;
  logic [3:0]  id_rs2 = '0;
  logic        id_rs1_ren = 1'b0;
  logic        id_rs2_ren = 1'b0;
  logic [3:0]  id_rd = '0;
  logic        id_wen = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_rd = '0;
  logic        wb_wen = 1'b0;
  logic        stall_id;
  logic [15:0] busy_vec;
  logic        sb_err;
  logic [31:0] perf_stall;

  ysyx_24100006_scoreboard dut (
    .clock       (clock),
    .reset       (reset),
    .id_out_valid(id_out_valid),
    .ex_in_ready (ex_in_ready),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_ren  (id_rs1_ren),
    .id_rs2_ren  (id_rs2_ren),
    .id_rd       (id_rd),
    .id_wen      (id_wen),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_wen      (wb_wen),
    .stall_id    (stall_id),
    .busy_vec    (busy_vec),
    .sb_err      (sb_err),
    .perf_stall  (perf_stall)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  int  m_cnt [16];
  bit  m_err;
  int  m_perf;
  bit  armed = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic bit m_stall();
    bit h1, h2, wf;
    h1 = id_rs1_ren && id_rs1 != 0 && m_cnt[id_rs1] != 0;
    h2 = id_rs2_ren && id_rs2 != 0 && m_cnt[id_rs2] != 0;
    wf = id_wen && id_rd != 0 && m_cnt[id_rd] == 3;
    return id_out_valid && (h1 || h2 || wf);
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b;
    b = '0;
    for (int i = 1; i < 16; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  // Reference model advances on each rising edge.
  always @(posedge clock) begin
    if (reset) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err  = 0;
      m_perf = 0;
      armed  = 1;
    end else if (armed) begin
      bit st, iss, ret;
      st  = m_stall();
      iss = id_out_valid && ex_in_ready && !st && id_wen && id_rd != 0;
      ret = wb_valid && wb_wen && wb_rd != 0;
      if (ret && m_cnt[wb_rd] == 0) m_err = 1;
      if (iss) m_cnt[id_rd]++;
      if (ret && m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
      if (st) m_perf++;
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      check("stall_id", stall_id, m_stall());
      check("busy_vec", busy_vec, m_busy());
      check("sb_err", sb_err, m_err);
      check("perf_stall", perf_stall, m_perf);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_out_valid = 0; ex_in_ready = 0;
    id_rs1 = 0; id_rs2 = 0; id_rs1_ren = 0; id_rs2_ren = 0;
    id_rd = 0; id_wen = 0;
    wb_valid = 0; wb_rd = 0; wb_wen = 0;
  endtask

  task automatic id_set(input bit v, input logic [3:0] rd, input bit wen,
                        input logic [3:0] rs1, input bit r1,
                        input logic [3:0] rs2, input bit r2);
    id_out_valid = v; ex_in_ready = 1;
    id_rd = rd; id_wen = wen;
    id_rs1 = rs1; id_rs1_ren = r1;
    id_rs2 = rs2; id_rs2_ren = r2;
  endtask

  task automatic wb_set(input bit v, input logic [3:0] rd);
    wb_valid = v; wb_wen = v; wb_rd = rd;
  endtask

  initial begin
    idle();
    reset = 1;
    cyc(2);
    reset = 0;
    #1;
    check("rst_busy", busy_vec, 16'h0000);
    check("rst_stall", stall_id, 0);
    check("rst_err", sb_err, 0);
    check("rst_perf", perf_stall, 0);

    // addi x5 issues, then add x6,x5,x5 waits in ID
    id_set(1, 5, 1, 0, 0, 0, 0);
    cyc(1);
    id_set(1, 6, 1, 5, 1, 5, 1);
    #1;
    check("raw_stall", stall_id, 1);
    check("raw_busy", busy_vec, 16'h0020);
    cyc(3);
    wb_set(1, 5);
    #1;
    check("raw_stall_ret", stall_id, 1);
    cyc(1);
    wb_set(0, 0);
    #1;
    check("raw_release", stall_id, 0);
    check("raw_busy_clr", busy_vec, 16'h0000);
    cyc(1);
    idle();
    #1;
    check("x6_busy", busy_vec, 16'h0040);
    wb_set(1, 6);
    cyc(1);
    idle();

    // x0 is never tracked
    id_set(1, 0, 1, 0, 0, 0, 0);
    cyc(1);
    id_set(1, 0, 1, 0, 1, 0, 1);
    #1;
    check("x0_stall", stall_id, 0);
    check("x0_busy", busy_vec, 16'h0000);
    cyc(1);
    idle();

    // Same-cycle issue and retire on x7
    id_set(1, 7, 1, 0, 0, 0, 0);
    cyc(1);
    wb_set(1, 7);
    #1;
    check("x7_same_stall", stall_id, 0);
    cyc(1);
    idle();
    #1;
    check("x7_hold", busy_vec, 16'h0080);
    wb_set(1, 7);
    cyc(1);
    idle();
    #1;
    check("x7_drain", busy_vec, 16'h0000);

    // WAW saturation on x3
    id_set(1, 3, 1, 0, 0, 0, 0);
    cyc(3);
    #1;
    check("waw_full_stall", stall_id, 1);
    check("waw_busy", busy_vec, 16'h0008);
    cyc(2);
    idle();
    wb_set(1, 3);
    cyc(2);
    #1;
    check("waw_after2", busy_vec, 16'h0008);
    cyc(1);
    wb_set(0, 0);
    #1;
    check("waw_after3", busy_vec, 16'h0000);
    check("waw_no_wrap_err", sb_err, 0);

    // Underflow on x9 is sticky
    wb_set(1, 9);
    cyc(1);
    wb_set(0, 0);
    #1;
    check("uf_err", sb_err, 1);
    id_set(1, 4, 1, 0, 0, 0, 0);
    cyc(1);
    idle();
    wb_set(1, 4);
    cyc(1);
    idle();
    #1;
    check("uf_sticky", sb_err, 1);
    check("uf_cnt_clean", busy_vec, 16'h0000);

    // Perf counter over a 10-cycle hazard, then reset mid-flight
    reset = 1;
    cyc(1);
    reset = 0;
    #1;
    check("err_cleared", sb_err, 0);
    check("perf_cleared", perf_stall, 0);
    id_set(1, 8, 1, 0, 0, 0, 0);
    cyc(1);
    id_set(1, 2, 1, 8, 1, 0, 0);
    cyc(10);
    id_out_valid = 0;
    #1;
    check("perf_10", perf_stall, 10);
    id_out_valid = 1;
    #1;
    check("pre_rst_stall", stall_id, 1);
    reset = 1;
    cyc(1);
    reset = 0;
    #1;
    check("post_rst_stall", stall_id, 0);
    check("post_rst_busy", busy_vec, 16'h0000);
    check("post_rst_perf", perf_stall, 0);
    cyc(1);
    idle();
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
